// File: rtl/sw_io_pkg.sv
// Shared definitions for the board switch / key front end.
//   OP_W_DEF, ADDR_W_DEF : default instruction field widths
//   KEY_ENTER, KEY_CLEAR : indices of the enter and clear push-buttons on KEY
//   instr_fields_t       : one captured instruction, packed MSB-first as
//                          {codop, addA, addB_LMM, addC}, matching the SW
//                          field map read LSB-up.
package sw_io_pkg;

  localparam int OP_W_DEF   = 4;
  localparam int ADDR_W_DEF = 4;

  localparam int KEY_ENTER = 0;
  localparam int KEY_CLEAR = 1;

  typedef struct packed {
    logic [OP_W_DEF-1:0]   codop;
    logic [ADDR_W_DEF-1:0] addA;
    logic [ADDR_W_DEF-1:0] addB_LMM;
    logic [ADDR_W_DEF-1:0] addC;
  } instr_fields_t;

endpackage

// File: rtl/key_debouncer.sv
// Synchronises and debounces one active-low push-button and emits a single
// registered pulse per debounced press (stable level 1 -> 0).
// Ports:
//   clk_i   : system clock
//   rst_i   : synchronous reset, active-high
//   key_i   : raw active-low key level from the pin
//   press_o : one-cycle pulse, one per accepted press; releases give nothing
//
// After reset the debouncer is disarmed: it only arms once the synchronised
// level has been released (high) for DEB_CYCLES consecutive cycles. A key
// still held down across reset therefore cannot fire until it is released
// and pressed again.
module key_debouncer #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic press_o
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          stable_dly_q;
  logic          armed_q, armed_d;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    armed_d  = armed_q;
    if (!armed_q) begin
      // Count a continuous release before any press may be recognised.
      if (sync2_q) begin
        if (cnt_q == CNT_LAST) begin
          armed_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end else if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      armed_q      <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= key_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      armed_q      <= armed_d;
      // Falling edge of the debounced level, registered once more.
      press_q      <= stable_dly_q & ~stable_q;
      cnt_q        <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/switches_instr_queue.sv
// Front-panel instruction entry: debounces KEY[0] (enter) and KEY[1] (clear),
// captures the synchronised SW instruction fields on each enter press into a
// small FIFO and presents the head entry to the CPU with valid/ready.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   KEY[3:0]          : active-low push-buttons (0 = enter, 1 = clear)
//   SW[SW_W-1:0]      : switches, LSB-up: addC, addB_LMM, addA, codop
//   codop/addA/addB_LMM/addC : head entry fields (qualify with instr_valid)
//   instr_valid       : FIFO non-empty
//   instr_ready       : consumer takes the head this cycle
//   fill_count        : entries held (0..DEPTH)
//   overflow          : sticky, an enter press found the FIFO full
//
// Handshake: the head is transferred on every clock edge where instr_valid
// and instr_ready are both high; the next head appears on the following
// cycle. instr_valid does not depend on instr_ready.
//
// Field outputs come from a registered head copy so that they hold the last
// popped value while empty and are untouched by a clear.
module switches_instr_queue
  import sw_io_pkg::*;
#(
  parameter int OP_W       = OP_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int SW_W       = 18,
  parameter int DEB_CYCLES = 50000,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               KEY,
  input  logic [SW_W-1:0]          SW,
  output logic [OP_W-1:0]          codop,
  output logic [ADDR_W-1:0]        addA,
  output logic [ADDR_W-1:0]        addB_LMM,
  output logic [ADDR_W-1:0]        addC,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   fill_count,
  output logic                     overflow
);

  localparam int ENTRY_W = OP_W + 3 * ADDR_W;
  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = PW + 1;

  // Switch synchroniser
  logic [SW_W-1:0] sw_s1_q, sw_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= SW;
      sw_s2_q <= sw_s1_q;
    end
  end

  // Switch bits above the instruction fields and KEY[3:2] carry nothing.
  if (SW_W > ENTRY_W) begin : g_sw_hi
    logic unused_sw_hi;
    assign unused_sw_hi = ^sw_s2_q[SW_W-1:ENTRY_W];
  end
  logic unused_key_hi;
  assign unused_key_hi = ^KEY[3:2];

  // Key events
  logic enter_ev, clear_ev;

  key_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_enter (
    .clk_i   (clk),
    .rst_i   (rst),
    .key_i   (KEY[KEY_ENTER]),
    .press_o (enter_ev)
  );

  key_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_clear (
    .clk_i   (clk),
    .rst_i   (rst),
    .key_i   (KEY[KEY_CLEAR]),
    .press_o (clear_ev)
  );

  // FIFO
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ENTRY_W-1:0] head_q, head_d;
  logic [ENTRY_W-1:0] entry_in;
  logic               valid, do_pop, do_push;

  assign entry_in = sw_s2_q[ENTRY_W-1:0];
  assign valid    = (cnt_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    head_d   = head_q;
    // Clear overrides both push and pop in the same cycle.
    do_pop   = valid && instr_ready && !clear_ev;
    // A full FIFO still accepts when the head leaves in the same cycle.
    do_push  = enter_ev && !clear_ev && ((cnt_q < CW'(DEPTH)) || do_pop);

    if (clear_ev) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (enter_ev && !do_push) ovf_d = 1'b1;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
      // Show-ahead: load whatever will sit at the read pointer next cycle,
      // bypassing the array when that slot is being written right now.
      if (cnt_d != '0) begin
        if (do_push && (wr_ptr_q == rd_ptr_d)) head_d = entry_in;
        else                                   head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      head_q   <= head_d;
    end
  end

  assign codop       = head_q[ENTRY_W-1 -: OP_W];
  assign addA        = head_q[3*ADDR_W-1 -: ADDR_W];
  assign addB_LMM    = head_q[2*ADDR_W-1 -: ADDR_W];
  assign addC        = head_q[ADDR_W-1 -: ADDR_W];
  assign instr_valid = valid;
  assign fill_count  = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/switches_instr_queue.md
Name: switches_instr_queue

Overview:
- Parametrised successor to the board switch reader: debounces front-panel KEYs and captures the SW instruction fields only on an explicit "enter" press.
- Queues captured instructions in a small FIFO and presents them to the CPU through a valid/ready handshake.
- Sits between the DE2 I/O pins and the CPU fetch/decode stage in the TP1 top level.

Parameters:
- OP_W, 4, codop field width
- ADDR_W, 4, width of each of addA, addB_LMM, addC
- SW_W, 18, board switch bus width; must be >= OP_W+3*ADDR_W
- DEB_CYCLES, 50000, clock cycles a key level must hold stable to be accepted (>=2)
- DEPTH, 4, FIFO entries; power of two, >=2

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- KEY  in  4  push-buttons, active-low; KEY[0]=enter, KEY[1]=clear, KEY[3:2] unused
- SW  in  SW_W  switches; field map LSB-up: addC, addB_LMM, addA, codop; bits above unused
- codop  out  OP_W  head-entry opcode
- addA  out  ADDR_W  head-entry operand A
- addB_LMM  out  ADDR_W  head-entry operand B / immediate
- addC  out  ADDR_W  head-entry destination
- instr_valid  out  1  FIFO non-empty; head fields valid
- instr_ready  in  1  consumer accepts head this cycle
- fill_count  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky: an enter press was dropped

Behaviour:
- Reset: synchronous, active-high, applied on the clk edge. Outputs codop, addA, addB_LMM, addC = 0; instr_valid = 0; fill_count = 0; overflow = 0. Debounced key states = 1 (released); sync flops = 1 for KEY, 0 for SW; debounce counters = 0; pointers = 0.
- Synchronisers: 2-flop on KEY[1:0] and on all of SW. Fields are always taken from the synchronised SW.
- Debounce, per key (KEY[0], KEY[1]):
  - Counter increments while synced level != stable level; clears to 0 whenever they are equal.
  - When counter reaches DEB_CYCLES-1 and levels still differ, stable level takes the synced level and counter clears.
  - A bounce shorter than DEB_CYCLES produces no event.
- Press event: registered one-cycle pulse on stable 1->0 only. Release generates nothing. Holding a key produces exactly one event.
- Latency: KEY[0] low and held from edge 0 gives instr_valid = 1 after exactly DEB_CYCLES+4 edges.
- Push on enter event:
  - Writes {codop, addA, addB_LMM, addC} sliced from synced SW in that cycle.
  - Accepted if fill_count < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped and overflow is set.
- Pop: when instr_valid && instr_ready. The read pointer advances, and the next head appears on the outputs the following cycle.
- Outputs: show-ahead. Fields are driven from the registered FIFO entry at the read pointer. While empty, fields hold the last popped value; the consumer must qualify them with instr_valid.
- Simultaneous push and pop: fill_count is unchanged and both pointers advance.
- Pointers: wrap modulo DEPTH. fill_count tracks full vs empty.
- Clear event (KEY[1]): on the next edge, fill_count = 0, pointers = 0, overflow = 0, instr_valid = 0. Field outputs are not modified.
- Clear and enter in the same cycle: clear wins and the enter entry is discarded. An enter on the following cycle behaves normally.
- Pop in the same cycle as clear: ignored.
- Reset mid-operation, including mid-debounce: all state returns to reset values. A key held through reset deassertion must first be released (stable 1) before a new press event can occur.
- fill_count never exceeds DEPTH. overflow never clears except by clear event or rst.

Decomposition:
- Shared package sw_io_pkg: field-width constants OP_W_DEF=4 and ADDR_W_DEF=4, KEY index constants (KEY_ENTER=0, KEY_CLEAR=1), and a packed instr_fields_t struct.
- Natural sub-module key_debouncer, instantiated twice: sync, counter, stable level, press pulse, DEB_CYCLES param.
- The FIFO stays inline.

Test Plan:
- Basic capture (DEB_CYCLES=4, DEPTH=4): SW=0x0A5C3, hold KEY[0] low 10 cycles -> instr_valid=1 at edge 8 with codop=0xA, addA=0x5, addB_LMM=0xC, addC=0x3; ready=1 -> empty next cycle, fill_count=0.
- Bounce rejection: KEY[0] low 3 cycles, high 1, low 3, then high -> no push, fill_count=0. Then hold low 6 cycles -> exactly one push.
- Fill and overflow: ready=0, five presses with SW=0x1111, 0x2222, 0x3333, 0x4444, 0x5555 -> fill_count=4, overflow=1. Pops return 1,2,3,4 in order; 0x5555 is never seen.
- Simultaneous push/pop at full: FIFO full, ready=1 on the enter-event cycle -> fill_count stays 4, new entry at tail, old head removed.
- Clear priority: KEY[0] and KEY[1] released-to-pressed on the same cycle with 2 entries queued -> fill_count=0, overflow=0, instr_valid=0, no new entry.
- Reset mid-debounce: KEY[0] low 2 cycles, rst pulse 1 cycle, KEY[0] kept low 20 cycles -> no push until a release and a new press.
